// File: rtl/spi_pkg.sv
// Shared definitions for the SPI slave transfer engine: mode encoding,
// FSM state constants and the default word length.
package spi_pkg;

  typedef enum logic [1:0] {
    MODE0 = 2'b00,
    MODE1 = 2'b01,
    MODE2 = 2'b10,
    MODE3 = 2'b11
  } spi_mode_e;

  localparam logic [0:0] ST_IDLE   = 1'b0;
  localparam logic [0:0] ST_ACTIVE = 1'b1;

  localparam int SPI_DATA_W_DEFAULT = 8;

  function automatic logic mode_cpol(spi_mode_e m);
    return m[1];
  endfunction

  function automatic logic mode_cpha(spi_mode_e m);
    return m[0];
  endfunction

endpackage

// File: rtl/spi_pin_sync.sv
// Multi-flop synchroniser for one asynchronous pin, with rise/fall pulses
// derived from one extra registered copy of the synchronised level.
module spi_pin_sync #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic pin_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);

  logic [STAGES-1:0] sync_q;
  logic              prev_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= {STAGES{RST_VAL}};
      prev_q <= RST_VAL;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], pin_i};
      prev_q <= sync_q[STAGES-1];
    end
  end

  assign level_o = sync_q[STAGES-1];
  assign rise_o  = level_o & ~prev_q;
  assign fall_o  = ~level_o & prev_q;

endmodule

// File: rtl/spi_slave_xfer_ctrl.sv
// SPI slave transfer engine: pin synchronisation, mode-dependent edge decode,
// bit counting, TX/RX shift registers and word handshakes with the host.
module spi_slave_xfer_ctrl
  import spi_pkg::*;
#(
  parameter int DATA_W      = SPI_DATA_W_DEFAULT,
  parameter int SYNC_STAGES = 2,
  parameter bit LSB_FIRST   = 1'b0
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       SCK_in,
  input  logic                       SS_n,
  input  logic                       MOSI,
  output logic                       MISO,
  output logic                       MISO_oe,
  input  logic                       CPOL,
  input  logic                       CPHA,
  output logic                       idle,
  input  logic [DATA_W-1:0]          tx_data,
  input  logic                       tx_valid,
  output logic                       tx_ready,
  output logic [DATA_W-1:0]          rx_data,
  output logic                       rx_valid,
  input  logic                       rx_ready,
  output logic                       rx_overrun,
  output logic                       tx_underrun,
  output logic [0:0]                 dbg_state_o,
  output logic [$clog2(DATA_W)-1:0]  dbg_bit_cnt_o
);

  localparam int                CNT_W = $clog2(DATA_W);
  localparam logic [CNT_W-1:0]  LAST_BIT = CNT_W'(DATA_W - 1);

  logic sck_lvl, sck_rise, sck_fall;
  logic ss_lvl, ss_rise, ss_fall;
  logic mosi_lvl, mosi_rise, mosi_fall;

  spi_pin_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sck_sync (
    .clk(clk), .rst_n(rst_n), .pin_i(SCK_in),
    .level_o(sck_lvl), .rise_o(sck_rise), .fall_o(sck_fall)
  );

  spi_pin_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_ss_sync (
    .clk(clk), .rst_n(rst_n), .pin_i(SS_n),
    .level_o(ss_lvl), .rise_o(ss_rise), .fall_o(ss_fall)
  );

  spi_pin_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_mosi_sync (
    .clk(clk), .rst_n(rst_n), .pin_i(MOSI),
    .level_o(mosi_lvl), .rise_o(mosi_rise), .fall_o(mosi_fall)
  );

  // Only the SCK edges, the SS_n level and the MOSI level drive the engine.
  logic unused_sync;
  assign unused_sync = ^{sck_lvl, ss_rise, ss_fall, mosi_rise, mosi_fall};

  logic [0:0]        state_q, state_d;
  spi_mode_e         mode_q, mode_d;
  logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic              need_load_q, need_load_d;
  logic [DATA_W-1:0] tx_sr_q, tx_sr_d;
  logic [DATA_W-1:0] rx_sr_q, rx_sr_d;
  logic [DATA_W-1:0] tx_buf_q, tx_buf_d;
  logic              tx_full_q, tx_full_d;
  logic [DATA_W-1:0] rx_data_q, rx_data_d;
  logic              rx_valid_q, rx_valid_d;
  logic              rx_overrun_q, rx_overrun_d;
  logic              tx_underrun_q, tx_underrun_d;

  logic              lead_edge, trail_edge, sample_edge, shift_edge;
  logic              load, word_done;
  logic [DATA_W-1:0] rx_word, tx_shifted;

  assign lead_edge   = mode_cpol(mode_q) ? sck_fall : sck_rise;
  assign trail_edge  = mode_cpol(mode_q) ? sck_rise : sck_fall;
  assign sample_edge = mode_cpha(mode_q) ? trail_edge : lead_edge;
  assign shift_edge  = mode_cpha(mode_q) ? lead_edge  : trail_edge;

  assign rx_word    = LSB_FIRST ? {mosi_lvl, rx_sr_q[DATA_W-1:1]}
                                : {rx_sr_q[DATA_W-2:0], mosi_lvl};
  assign tx_shifted = LSB_FIRST ? {1'b1, tx_sr_q[DATA_W-1:1]}
                                : {tx_sr_q[DATA_W-2:0], 1'b1};

  always_comb begin
    state_d       = state_q;
    mode_d        = mode_q;
    bit_cnt_d     = bit_cnt_q;
    need_load_d   = need_load_q;
    tx_sr_d       = tx_sr_q;
    rx_sr_d       = rx_sr_q;
    tx_buf_d      = tx_buf_q;
    tx_full_d     = tx_full_q;
    rx_data_d     = rx_data_q;
    rx_valid_d    = rx_valid_q;
    rx_overrun_d  = 1'b0;
    tx_underrun_d = 1'b0;
    load          = 1'b0;
    word_done     = 1'b0;

    if (state_q == ST_IDLE) begin
      mode_d      = spi_mode_e'({CPOL, CPHA});
      bit_cnt_d   = '0;
      need_load_d = 1'b0;
      // Entry uses the live CPHA, which is the value being latched this clk.
      if (!ss_lvl) begin
        state_d = ST_ACTIVE;
        if (CPHA) need_load_d = 1'b1;
        else      load        = 1'b1;
      end
    end else if (ss_lvl) begin
      // Deselect wins over any coincident sample edge; partial word is dropped.
      state_d     = ST_IDLE;
      bit_cnt_d   = '0;
      need_load_d = 1'b0;
    end else begin
      if (sample_edge) begin
        rx_sr_d = rx_word;
        if (bit_cnt_q == LAST_BIT) begin
          bit_cnt_d   = '0;
          word_done   = 1'b1;
          need_load_d = 1'b1;
        end else begin
          bit_cnt_d = bit_cnt_q + CNT_W'(1);
        end
      end
      if (shift_edge) begin
        if (need_load_q) begin
          load        = 1'b1;
          need_load_d = 1'b0;
        end else begin
          tx_sr_d = tx_shifted;
        end
      end
    end

    if (load) begin
      if (tx_full_q) begin
        tx_sr_d   = tx_buf_q;
        tx_full_d = 1'b0;
      end else begin
        tx_sr_d       = '1;
        tx_underrun_d = 1'b1;
      end
    end

    if (tx_valid && !tx_full_q) begin
      tx_buf_d  = tx_data;
      tx_full_d = 1'b1;
    end

    // Handshake: a same-clk accept frees the slot for a completing word.
    if (rx_valid_q && rx_ready) rx_valid_d = 1'b0;
    if (word_done) begin
      if (!rx_valid_q || rx_ready) begin
        rx_data_d  = rx_word;
        rx_valid_d = 1'b1;
      end else begin
        rx_overrun_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      mode_q        <= MODE0;
      bit_cnt_q     <= '0;
      need_load_q   <= 1'b0;
      tx_sr_q       <= '1;
      rx_sr_q       <= '0;
      tx_buf_q      <= '0;
      tx_full_q     <= 1'b0;
      rx_data_q     <= '0;
      rx_valid_q    <= 1'b0;
      rx_overrun_q  <= 1'b0;
      tx_underrun_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      mode_q        <= mode_d;
      bit_cnt_q     <= bit_cnt_d;
      need_load_q   <= need_load_d;
      tx_sr_q       <= tx_sr_d;
      rx_sr_q       <= rx_sr_d;
      tx_buf_q      <= tx_buf_d;
      tx_full_q     <= tx_full_d;
      rx_data_q     <= rx_data_d;
      rx_valid_q    <= rx_valid_d;
      rx_overrun_q  <= rx_overrun_d;
      tx_underrun_q <= tx_underrun_d;
    end
  end

  assign MISO          = (state_q == ST_ACTIVE)
                         ? (LSB_FIRST ? tx_sr_q[0] : tx_sr_q[DATA_W-1]) : 1'b1;
  assign MISO_oe       = (state_q == ST_ACTIVE);
  assign idle          = (state_q == ST_IDLE);
  assign tx_ready      = ~tx_full_q;
  assign rx_data       = rx_data_q;
  assign rx_valid      = rx_valid_q;
  assign rx_overrun    = rx_overrun_q;
  assign tx_underrun   = tx_underrun_q;
  assign dbg_state_o   = state_q;
  assign dbg_bit_cnt_o = bit_cnt_q;

endmodule
